// File: rtl/matrix_pkg.sv
// Shared types and sizes for the LED-matrix framebuffer and its port arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package matrix_pkg;

  localparam int PIXEL_WIDTH = 24;
  localparam int ROW_BITS    = 4;
  localparam int COL_BITS    = 6;
  localparam int ADDR_BITS   = 1 + ROW_BITS + COL_BITS;

  typedef logic [PIXEL_WIDTH-1:0]   pixel_t;
  typedef logic [2*PIXEL_WIDTH-1:0] pixel_word_t;
  typedef logic [ADDR_BITS-1:0]     ram_addr_t;
  typedef logic [ROW_BITS-1:0]      row_t;
  typedef logic [COL_BITS-1:0]      col_t;

  // One held host write: where it goes, which half of the word, and the pixel.
  typedef struct packed {
    row_t   row;
    col_t   col;
    logic   half;
    pixel_t data;
  } wr_req_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // RAM word address is {bank, row, col}.
  function automatic ram_addr_t make_addr(input logic bank, input row_t row, input col_t col);
    return {bank, row, col};
  endfunction

endpackage

// File: rtl/fb_write_hold.sv
// Depth-1 holding register for host pixel writes.
// Latency: a write accepted in cycle N is presented from cycle N+1 until popped.
// Backpressure: ready only when empty and allowed; a new load is possible the cycle after a pop.
module fb_write_hold
  import matrix_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_reset,
  input  logic    i_allow,
  input  logic    i_wr_vld,
  input  wr_req_t i_wr_dat,
  output logic    o_wr_rdy,
  output logic    o_hold_vld,
  output wr_req_t o_hold_dat,
  input  logic    i_pop
);

  logic    r_full;
  wr_req_t r_req;

  assign o_wr_rdy   = !i_reset && !r_full && i_allow;
  assign o_hold_vld = r_full;
  assign o_hold_dat = r_req;

  // Load on handshake, empty when the arbiter issues the write; ready excludes full so both never coincide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_full <= 1'b0;
      r_req  <= '0;
    end else if (i_wr_vld && o_wr_rdy) begin
      r_full <= 1'b1;
      r_req  <= i_wr_dat;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the single RAM port between scan reads (always served) and host writes to the back bank.
// Latency: scan data 2 cycles after scan_rd_en; a held write issues in the first cycle without scan.
// Backpressure: wr_ready drops while the holding register is full or a bank swap is pending.
module framebuffer_arbiter
  import matrix_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  scan_rd_en,
  input  logic [ROW_BITS-1:0]   scan_row,
  input  logic [COL_BITS-1:0]   scan_col,
  output logic [2*PIXEL_WIDTH-1:0] scan_rd_data,
  output logic                  scan_rd_valid,
  input  logic                  frame_sync,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ROW_BITS-1:0]   wr_row,
  input  logic [COL_BITS-1:0]   wr_col,
  input  logic                  wr_half,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  output logic                  front_bank,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic                  ram_we,
  output logic [1:0]            ram_be,
  output logic [2*PIXEL_WIDTH-1:0] ram_wdata,
  input  logic [2*PIXEL_WIDTH-1:0] ram_rdata
);

  swap_state_t r_state;
  logic        r_front;
  logic        r_swap_done;
  logic        r_rd_p1;
  logic        r_rd_valid;
  pixel_word_t r_rd_data;

  logic    w_hold_vld;
  wr_req_t w_hold_dat;
  wr_req_t w_wr_dat;
  logic    w_issue_wr;

  assign w_wr_dat   = '{row: wr_row, col: wr_col, half: wr_half, data: wr_data};
  // Scan owns the port whenever it asks; the held write only fills idle cycles.
  assign w_issue_wr = !reset && !scan_rd_en && w_hold_vld;

  fb_write_hold u_hold (
    .i_clk      (clk_in),
    .i_reset    (reset),
    .i_allow    (r_state == SWAP_IDLE),
    .i_wr_vld   (wr_valid),
    .i_wr_dat   (w_wr_dat),
    .o_wr_rdy   (wr_ready),
    .o_hold_vld (w_hold_vld),
    .o_hold_dat (w_hold_dat),
    .i_pop      (w_issue_wr)
  );

  // Per-cycle port decision: scan read from the front bank, else the held write to the back bank.
  always_comb begin
    ram_addr = make_addr(r_front, scan_row, scan_col);
    ram_we   = 1'b0;
    ram_be   = 2'b00;
    if (w_issue_wr) begin
      ram_addr = make_addr(~r_front, w_hold_dat.row, w_hold_dat.col);
      ram_we   = 1'b1;
      ram_be   = w_hold_dat.half ? 2'b10 : 2'b01;
    end
  end

  assign ram_wdata = {w_hold_dat.data, w_hold_dat.data};

  // Scan return path: RAM answers one cycle after the address, then one register stage.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_rd_p1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_p1    <= scan_rd_en;
      r_rd_valid <= r_rd_p1;
      if (r_rd_p1) begin
        r_rd_data <= ram_rdata;
      end
    end
  end

  // Swap FSM: a request waits for a frame boundary with no write still held, so no frame is torn.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state     <= SWAP_IDLE;
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        SWAP_IDLE: begin
          if (swap_req) begin
            r_state <= SWAP_PENDING;
          end
        end
        SWAP_PENDING: begin
          if (frame_sync && !w_hold_vld) begin
            r_state     <= SWAP_IDLE;
            r_front     <= ~r_front;
            r_swap_done <= 1'b1;
          end
        end
        default: r_state <= SWAP_IDLE;
      endcase
    end
  end

  assign scan_rd_data  = r_rd_data;
  assign scan_rd_valid = r_rd_valid;
  assign swap_pending  = (r_state == SWAP_PENDING);
  assign swap_done     = r_swap_done;
  assign front_bank    = r_front;

endmodule
